// File: rtl/patch_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : patch_fetcher
// Purpose  : Walks a stored image in raster order and delivers every 3x3
//            stride-1 window to the downstream window register.
// Revision : 1.0 - initial release
// ============================================================================
module patch_fetcher #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [71:0]       patch_pixels,
    output logic              load_full_patch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              patch_last,
    output logic              done
);

    localparam int C_CW = $clog2(IMG_W);
    localparam int C_RW = $clog2(IMG_H);
    localparam logic [C_CW-1:0]   C_C_LAST = C_CW'(IMG_W - 3);
    localparam logic [C_RW-1:0]   C_R_LAST = C_RW'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] C_STRIDE = ADDR_W'(IMG_W);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH_FULL = 3'd1;
    localparam logic [2:0] S_FETCH_COL  = 3'd2;
    localparam logic [2:0] S_DRAIN      = 3'd3;
    localparam logic [2:0] S_PRESENT    = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [C_RW-1:0]   r_r;
    logic [C_CW-1:0]   r_c;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_frow_base;
    logic [1:0]        r_frow;
    logic [1:0]        r_fcol;
    logic              r_cap_vld;
    logic [1:0]        r_cap_row;
    logic [1:0]        r_cap_col;
    logic              r_cap_shift;
    logic [7:0]        r_pix [9];
    logic              w_last_fetch;
    logic              w_c_end;
    logic              w_r_end;
    logic [3:0]        w_i0;
    logic [3:0]        w_i1;
    logic [3:0]        w_i2;
    logic [3:0]        w_iw;

    assign w_c_end      = (r_c == C_C_LAST);
    assign w_r_end      = (r_r == C_R_LAST);
    assign w_last_fetch = (r_frow == 2'd2) && ((r_state == S_FETCH_COL) || (r_fcol == 2'd2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (start) w_next = S_FETCH_FULL;
            S_FETCH_FULL,
            S_FETCH_COL:  if (w_last_fetch) w_next = S_DRAIN;
            S_DRAIN:      w_next = S_PRESENT;
            S_PRESENT: begin
                if (out_ready) begin
                    if (!w_c_end)      w_next = S_FETCH_COL;
                    else if (!w_r_end) w_next = S_FETCH_FULL;
                    else               w_next = S_DONE;
                end
            end
            S_DONE:       w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = (r_state != S_IDLE);
        mem_rd_en       = (r_state == S_FETCH_FULL) || (r_state == S_FETCH_COL);
        out_valid       = (r_state == S_PRESENT);
        done            = (r_state == S_DONE);
        load_full_patch = out_valid && (r_c == '0);
        patch_last      = out_valid && w_c_end && w_r_end;
        mem_addr        = mem_rd_en ? (r_frow_base + ADDR_W'(r_c) + ADDR_W'(r_fcol)) : '0;
    end

    // r_frow_base is the RAM address of column 0 of the image row being read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r         <= '0;
            r_c         <= '0;
            r_row_base  <= '0;
            r_frow_base <= '0;
            r_frow      <= '0;
            r_fcol      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_r         <= '0;
                        r_c         <= '0;
                        r_row_base  <= '0;
                        r_frow_base <= '0;
                        r_frow      <= '0;
                        r_fcol      <= '0;
                    end
                end
                S_FETCH_FULL: begin
                    if (r_fcol == 2'd2) begin
                        r_fcol      <= '0;
                        r_frow      <= r_frow + 2'd1;
                        r_frow_base <= r_frow_base + C_STRIDE;
                    end else begin
                        r_fcol      <= r_fcol + 2'd1;
                    end
                end
                S_FETCH_COL: begin
                    r_frow      <= r_frow + 2'd1;
                    r_frow_base <= r_frow_base + C_STRIDE;
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        r_frow <= '0;
                        if (!w_c_end) begin
                            r_c         <= r_c + C_CW'(1);
                            r_fcol      <= 2'd2;
                            r_frow_base <= r_row_base;
                        end else if (!w_r_end) begin
                            r_c         <= '0;
                            r_r         <= r_r + C_RW'(1);
                            r_row_base  <= r_row_base + C_STRIDE;
                            r_frow_base <= r_row_base + C_STRIDE;
                            r_fcol      <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data lands one cycle after the strobe, so the target slot travels with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_vld   <= 1'b0;
            r_cap_row   <= '0;
            r_cap_col   <= '0;
            r_cap_shift <= 1'b0;
        end else begin
            r_cap_vld   <= mem_rd_en;
            r_cap_row   <= r_frow;
            r_cap_col   <= r_fcol;
            r_cap_shift <= (r_state == S_FETCH_COL);
        end
    end

    assign w_i0 = {1'b0, r_cap_row, 1'b0} + {2'b00, r_cap_row};
    assign w_i1 = w_i0 + 4'd1;
    assign w_i2 = w_i0 + 4'd2;
    assign w_iw = w_i0 + {2'b00, r_cap_col};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) r_pix[i] <= '0;
        end else if (r_cap_vld) begin
            if (r_cap_shift) begin
                r_pix[w_i0] <= r_pix[w_i1];
                r_pix[w_i1] <= r_pix[w_i2];
                r_pix[w_i2] <= mem_rdata;
            end else begin
                r_pix[w_iw] <= mem_rdata;
            end
        end
    end

    for (genvar g = 0; g < 9; g++) begin : g_pack
        assign patch_pixels[8*g +: 8] = r_pix[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_patch_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_patch_fetcher
// Purpose  : Self-checking bench for patch_fetcher on 4x4, 3x3 and 5x4 images.
// Revision : 1.0 - initial release
// ============================================================================
module tb_patch_fetcher;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    logic       start_s [3];
    logic       ready_s [3];
    logic       busy_s  [3];
    logic       rd_s    [3];
    logic [9:0] addr_s  [3];
    logic [7:0] rdata_s [3];
    logic [71:0] patch_s [3];
    logic       full_s  [3];
    logic       valid_s [3];
    logic       last_s  [3];
    logic       done_s  [3];

    logic [7:0] mem [3][1024];
    int Wp [3] = '{4, 3, 5};
    int Hp [3] = '{4, 3, 4};

    int  rmode [3] = '{0, 0, 0};
    int  stall_left = 0;
    bit  active [3] = '{0, 0, 0};
    bit  prev_valid [3] = '{0, 0, 0};
    int  widx [3] = '{0, 0, 0};
    int  ev_cyc [3] = '{0, 0, 0};
    int  last_xfer [3] = '{0, 0, 0};
    int  grp [3] = '{0, 0, 0};
    int  done_cnt [3] = '{0, 0, 0};
    int  addr_q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    patch_fetcher #(.IMG_W(4), .IMG_H(4), .ADDR_W(10)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]),
        .mem_rd_en(rd_s[0]), .mem_addr(addr_s[0]), .mem_rdata(rdata_s[0]),
        .patch_pixels(patch_s[0]), .load_full_patch(full_s[0]), .out_valid(valid_s[0]),
        .out_ready(ready_s[0]), .patch_last(last_s[0]), .done(done_s[0]));

    patch_fetcher #(.IMG_W(3), .IMG_H(3), .ADDR_W(10)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]),
        .mem_rd_en(rd_s[1]), .mem_addr(addr_s[1]), .mem_rdata(rdata_s[1]),
        .patch_pixels(patch_s[1]), .load_full_patch(full_s[1]), .out_valid(valid_s[1]),
        .out_ready(ready_s[1]), .patch_last(last_s[1]), .done(done_s[1]));

    patch_fetcher #(.IMG_W(5), .IMG_H(4), .ADDR_W(10)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_s[2]), .busy(busy_s[2]),
        .mem_rd_en(rd_s[2]), .mem_addr(addr_s[2]), .mem_rdata(rdata_s[2]),
        .patch_pixels(patch_s[2]), .load_full_patch(full_s[2]), .out_valid(valid_s[2]),
        .out_ready(ready_s[2]), .patch_last(last_s[2]), .done(done_s[2]));

    // Image RAM: one-cycle read latency
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            if (rd_s[k]) rdata_s[k] <= mem[k][addr_s[k]];
    end

    task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic string tg(input string s, input int k);
        return $sformatf("%s[%0d]", s, k);
    endfunction

    function automatic logic [71:0] exp_patch(input int k, input int idx);
        int w = Wp[k];
        int r = idx / (w - 2);
        int c = idx % (w - 2);
        logic [71:0] p = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[8*(3*i+j) +: 8] = mem[k][(r+i)*w + c + j];
        return p;
    endfunction

    task automatic begin_frame(input int k);
        int w = Wp[k];
        int tot = (Wp[k]-2) * (Hp[k]-2);
        active[k] = 1; widx[k] = 0; ev_cyc[k] = cyc; grp[k] = 0; prev_valid[k] = 0;
        addr_q[k].delete();
        for (int idx = 0; idx < tot; idx++) begin
            int r = idx / (w - 2);
            int c = idx % (w - 2);
            for (int i = 0; i < 3; i++) begin
                if (c == 0) for (int j = 0; j < 3; j++) addr_q[k].push_back((r+i)*w + c + j);
                else addr_q[k].push_back((r+i)*w + c + 2);
            end
        end
    endtask

    task automatic mon_active(input int k);
        int w = Wp[k];
        int tot = (Wp[k]-2) * (Hp[k]-2);
        check(tg("busy", k), busy_s[k], 1);
        if (rd_s[k]) begin
            if (grp[k] == 0) check(tg("rd_start_cyc", k), cyc, ev_cyc[k] + 1);
            grp[k]++;
            if (addr_q[k].size() == 0) check(tg("rd_extra", k), rd_s[k], 0);
            else check(tg("rd_addr", k), addr_s[k], addr_q[k].pop_front());
        end
        if (valid_s[k]) begin
            check(tg("rd_in_present", k), rd_s[k], 0);
            if (widx[k] >= tot) check(tg("extra_patch", k), valid_s[k], 0);
            else begin
                int c = widx[k] % (w - 2);
                if (!prev_valid[k]) check(tg("valid_cyc", k), cyc, ev_cyc[k] + ((c == 0) ? 11 : 5));
                check(tg("patch", k), patch_s[k], exp_patch(k, widx[k]));
                check(tg("full", k), full_s[k], c == 0);
                check(tg("last", k), last_s[k], widx[k] == tot - 1);
                if (ready_s[k]) begin
                    widx[k]++; ev_cyc[k] = cyc; last_xfer[k] = cyc; grp[k] = 0;
                end
            end
        end
        if (done_s[k]) begin
            check(tg("done_cyc", k), cyc, last_xfer[k] + 1);
            check(tg("done_windows", k), widx[k], tot);
            active[k] = 0;
            done_cnt[k]++;
        end
        prev_valid[k] = valid_s[k];
    endtask

    // Reference monitor: sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                active[k] = 0; prev_valid[k] = 0; addr_q[k].delete();
            end else if (active[k]) begin
                mon_active(k);
            end else begin
                check(tg("idle_valid", k), valid_s[k], 0);
                check(tg("idle_rd", k), rd_s[k], 0);
                check(tg("idle_done", k), done_s[k], 0);
                check(tg("idle_busy", k), busy_s[k], 0);
                if (start_s[k]) begin_frame(k);
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) ready_s[k] = 1'b1;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                case (rmode[k])
                    0: ready_s[k] = 1'b1;
                    1: begin
                        if (valid_s[k] && widx[k] == 1 && stall_left > 0) begin
                            ready_s[k] = 1'b0;
                            stall_left--;
                        end else ready_s[k] = 1'b1;
                    end
                    default: ready_s[k] = ($urandom_range(0, 3) != 0);
                endcase
            end
        end
    end

    task automatic check_zero(input int k);
        check(tg("rst_busy", k), busy_s[k], 0);
        check(tg("rst_rd", k), rd_s[k], 0);
        check(tg("rst_addr", k), addr_s[k], 0);
        check(tg("rst_valid", k), valid_s[k], 0);
        check(tg("rst_full", k), full_s[k], 0);
        check(tg("rst_last", k), last_s[k], 0);
        check(tg("rst_done", k), done_s[k], 0);
        check(tg("rst_patch", k), patch_s[k], 0);
    endtask

    task automatic pulse_start(input int k);
        @(posedge clk); #1;
        start_s[k] = 1'b1;
        @(posedge clk); #1;
        start_s[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int d0 = done_cnt[k];
        int n = 0;
        while (done_cnt[k] == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(tg("done_timeout", k), done_cnt[k] != d0, 1);
        repeat (3) @(posedge clk);
        check(tg("done_once", k), done_cnt[k] - d0, 1);
    endtask

    task automatic wait_widx(input int k, input int target);
        int n = 0;
        while (widx[k] < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        check(tg("widx_timeout", k), widx[k] >= target, 1);
    endtask

    task automatic fill_ramp(input int k);
        for (int a = 0; a < 1024; a++) mem[k][a] = 8'(a);
    endtask

    task automatic run_random(input int k);
        rmode[k] = 2;
        for (int a = 0; a < 1024; a++) mem[k][a] = 8'($urandom);
        pulse_start(k);
        repeat ($urandom_range(1, 5)) @(posedge clk);
        pulse_start(k);
        wait_done(k, 3000);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            fill_ramp(k);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) check_zero(k);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;

        // 4x4 ramp image, always ready
        pulse_start(0);
        wait_done(0, 500);

        // Five cycles of backpressure on the second patch
        rmode[0] = 1; stall_left = 5;
        pulse_start(0);
        wait_done(0, 500);
        check("stall_cycles_used", stall_left, 0);
        rmode[0] = 0;

        // A second start during a column fetch must be ignored
        pulse_start(0);
        wait_widx(0, 1);
        pulse_start(0);
        wait_done(0, 500);

        // Asynchronous reset in the middle of the first full fetch
        pulse_start(0);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_zero(0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        wait_done(0, 500);

        // Minimal 3x3 image and the 5x4 address pattern
        pulse_start(1);
        wait_done(1, 500);
        pulse_start(2);
        wait_done(2, 500);

        // Random data and random backpressure on all three images concurrently
        repeat (4) begin
            fork
                run_random(0);
                run_random(1);
                run_random(2);
            join
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
